// File: rtl/mc_datapath_core.sv
// Multi-cycle MIPS-subset datapath: instruction handshake, internal RF/ALU/DMEM,
// sequenced by a DECODE/EXEC/MEM/WB FSM, plus a debug port into the register file.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for an instruction; debug writes honoured here
// DECODE | read rs/rt, sign-extend imm, reject unsupported encodings
// EXEC   | ALU result (or memory address) into result register
// MEM    | SW writes DMEM; LW issues a synchronous read
// WB     | register write-back and o_done pulse
module mc_datapath_core #(
   parameter int DATA_W    = 32,
   parameter int RF_ADDR_W = 5,
   parameter int DMEM_AW   = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [31:0]          i_instr,
   input  logic                 i_instr_valid,
   output logic                 o_instr_ready,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [DATA_W-1:0]    o_result,
   output logic                 o_illegal,
   input  logic                 i_dbg_we,
   input  logic [RF_ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0]    i_dbg_wdata,
   input  logic [RF_ADDR_W-1:0] i_dbg_raddr,
   output logic [DATA_W-1:0]    o_dbg_rdata
);

   localparam int RF_DEPTH   = 2**RF_ADDR_W;
   localparam int DMEM_DEPTH = 2**DMEM_AW;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
   state_t state, state_nxt;

   // Captured instruction; imm_q also carries rd and funct for R-type.
   logic [5:0]  op_q;
   logic [4:0]  rs_q, rt_q;
   logic [15:0] imm_q;
   logic [5:0]  fn;
   logic [RF_ADDR_W-1:0] rs_a, rt_a, rd_a;

   logic [DATA_W-1:0] rf [RF_DEPTH];
   logic [DATA_W-1:0] dmem [DMEM_DEPTH];
   logic [DATA_W-1:0] a_q, b_q, simm_q, result_q, mem_rd_q, alu;
   logic [DMEM_AW-1:0] mem_addr;

   logic is_r, is_addi, is_lw, is_sw, legal;
   logic dbg_wr, wb_wr, rf_we;
   logic [RF_ADDR_W-1:0] rf_wa;
   logic [DATA_W-1:0]    rf_wd;

   assign fn   = imm_q[5:0];
   assign rs_a = RF_ADDR_W'(rs_q);
   assign rt_a = RF_ADDR_W'(rt_q);
   assign rd_a = RF_ADDR_W'(imm_q[15:11]);

   assign is_r    = (op_q == OP_RTYPE) &&
                    (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT);
   assign is_addi = (op_q == OP_ADDI);
   assign is_lw   = (op_q == OP_LW);
   assign is_sw   = (op_q == OP_SW);
   assign legal   = is_r || is_addi || is_lw || is_sw;

   always_comb begin
      alu = a_q + simm_q;
      if (op_q == OP_RTYPE) begin
         case (fn)
            FN_ADD:  alu = a_q + b_q;
            FN_SUB:  alu = a_q - b_q;
            FN_AND:  alu = a_q & b_q;
            FN_OR:   alu = a_q | b_q;
            FN_SLT:  alu = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      o_illegal = 1'b0;
      case (state)
         S_IDLE:   if (i_instr_valid) state_nxt = S_DECODE;
         S_DECODE: begin
            if (!legal) begin
               o_illegal = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC:   state_nxt = (is_lw || is_sw) ? S_MEM : S_WB;
         S_MEM:    state_nxt = S_WB;
         S_WB:     state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign o_instr_ready = (state == S_IDLE);
   assign o_busy        = (state != S_IDLE);
   assign o_done        = (state == S_WB);
   assign o_result      = (state == S_WB && is_lw) ? mem_rd_q : result_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q     <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         simm_q   <= '0;
         result_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_instr_valid) begin
                  op_q  <= i_instr[31:26];
                  rs_q  <= i_instr[25:21];
                  rt_q  <= i_instr[20:16];
                  imm_q <= i_instr[15:0];
               end
            end
            S_DECODE: begin
               a_q    <= rf[rs_a];
               b_q    <= rf[rt_a];
               simm_q <= DATA_W'($signed(imm_q));
            end
            S_EXEC:  result_q <= alu;
            default: ;
         endcase
      end
   end

   // Word address; byte-offset bits and bits above the memory depth are dropped.
   assign mem_addr = result_q[DMEM_AW+1:2];

   always_ff @(posedge i_clk) begin
      if (state == S_MEM && is_sw) dmem[mem_addr] <= b_q;
      mem_rd_q <= dmem[mem_addr];
   end

   // r0 is never written, so it keeps its reset value of zero.
   assign dbg_wr = (state == S_IDLE) && i_dbg_we;
   assign wb_wr  = (state == S_WB) && (is_r || is_addi || is_lw);
   assign rf_wa  = dbg_wr ? i_dbg_addr : (is_r ? rd_a : rt_a);
   assign rf_wd  = dbg_wr ? i_dbg_wdata : o_result;
   assign rf_we  = (dbg_wr || wb_wr) && (rf_wa != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
      end else if (rf_we) begin
         rf[rf_wa] <= rf_wd;
      end
   end

   assign o_dbg_rdata = rf[i_dbg_raddr];

endmodule
